vend_fsm_multi: RTL and testbench

//  Parametrised multi-product vending controller; successor to the single-price soda/diet FSM.

---
 rtl/vend_fsm_multi.sv | 157 +++++++++++++++
 tb/tb_vend_fsm_multi.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/vend_fsm_multi.sv
// Multi-product vending controller. Credit is kept in nickels, every product
// costs PRICE, each product has its own stock counter, and refunds go out one nickel per pulse.

module vend_stock_ctr #(
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_dec,
  input  logic i_restock,
  output logic o_empty
);
  logic [STOCK_W-1:0] r_stock;
  logic               r_empty;

  // A restock on the same edge as a decrement wins over the decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stock <= STOCK_W'(STOCK_INIT);
      r_empty <= (STOCK_INIT == 0);
    end else if (i_restock) begin
      r_stock <= STOCK_W'(STOCK_INIT);
      r_empty <= (STOCK_INIT == 0);
    end else if (i_dec && (r_stock != '0)) begin
      r_stock <= r_stock - 1'b1;
      r_empty <= (r_stock == STOCK_W'(1));
    end
  end

  assign o_empty = r_empty;
endmodule

module vend_fsm_multi #(
  parameter int PRICE      = 9,
  parameter int MAX_CREDIT = 13,
  parameter int CREDIT_W   = 5,
  parameter int N_PROD     = 2,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                quarter,
  input  logic                dime,
  input  logic                nickel,
  input  logic [N_PROD-1:0]   sel,
  input  logic                cancel,
  input  logic                restock,
  output logic [N_PROD-1:0]   vend,
  output logic                change,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic [N_PROD-1:0]   empty,
  output logic                busy
);
  localparam int SUM_W = CREDIT_W + 3;

  typedef enum logic [1:0] {S_IDLE, S_VEND, S_CHANGE} state_t;

  state_t              r_state, w_next;
  logic [CREDIT_W-1:0] r_credit, w_credit_nxt;
  logic [N_PROD-1:0]   r_vend, w_vend_nxt, w_dec, w_sel_oh, w_empty;
  logic                r_change, r_busy, r_rej, w_rej_nxt;
  logic                w_found, w_sel_ok, w_any_coin, w_multi;
  logic [SUM_W-1:0]    w_coin_val, w_sum;

  for (genvar g = 0; g < N_PROD; g++) begin : g_stock
    vend_stock_ctr #(.STOCK_W(STOCK_W), .STOCK_INIT(STOCK_INIT)) u_ctr (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_dec    (w_dec[g]),
      .i_restock(restock),
      .o_empty  (w_empty[g])
    );
  end

  // Of the requested products that are in stock, the lowest index is served.
  always_comb begin
    w_sel_oh = '0;
    w_found  = 1'b0;
    for (int i = 0; i < N_PROD; i++) begin
      if (!w_found && sel[i] && !w_empty[i]) begin
        w_sel_oh[i] = 1'b1;
        w_found     = 1'b1;
      end
    end
    w_sel_ok = w_found && (r_credit >= CREDIT_W'(PRICE));
  end

  assign w_any_coin = quarter | dime | nickel;
  assign w_multi    = (quarter & dime) | (quarter & nickel) | (dime & nickel);
  assign w_coin_val = quarter ? SUM_W'(5) : dime ? SUM_W'(2) : nickel ? SUM_W'(1) : '0;
  assign w_sum      = SUM_W'(r_credit) + w_coin_val;

  always_comb begin
    w_next       = r_state;
    w_credit_nxt = r_credit;
    w_vend_nxt   = '0;
    w_dec        = '0;
    w_rej_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cancel && (r_credit != '0)) begin
          w_next    = S_CHANGE;
          w_rej_nxt = w_any_coin;
        end else if (w_sel_ok) begin
          w_next       = S_VEND;
          w_vend_nxt   = w_sel_oh;
          w_dec        = w_sel_oh;
          w_credit_nxt = r_credit - CREDIT_W'(PRICE);
          w_rej_nxt    = w_any_coin;
        end else if (w_any_coin) begin
          // Only the highest-value coin is considered; any other coin is returned.
          if (w_sum > SUM_W'(MAX_CREDIT)) w_rej_nxt = 1'b1;
          else                            w_credit_nxt = w_sum[CREDIT_W-1:0];
          if (w_multi) w_rej_nxt = 1'b1;
        end
      end
      S_VEND: begin
        w_next    = (r_credit != '0) ? S_CHANGE : S_IDLE;
        w_rej_nxt = w_any_coin;
      end
      S_CHANGE: begin
        w_rej_nxt = w_any_coin;
        if (r_credit != '0) w_credit_nxt = r_credit - 1'b1;
        if (r_credit <= CREDIT_W'(1)) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_credit <= '0;
      r_vend   <= '0;
      r_change <= 1'b0;
      r_busy   <= 1'b0;
      r_rej    <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_credit <= w_credit_nxt;
      r_vend   <= w_vend_nxt;
      r_change <= (w_next == S_CHANGE);
      r_busy   <= (w_next != S_IDLE);
      r_rej    <= w_rej_nxt;
    end
  end

  assign vend        = r_vend;
  assign change      = r_change;
  assign coin_reject = r_rej;
  assign credit      = r_credit;
  assign empty       = w_empty;
  assign busy        = r_busy;
endmodule

// File: tb/tb_vend_fsm_multi.sv
// Randomised plus directed bench for vend_fsm_multi. A cycle-level behavioural
// model predicts the outputs, and a monitor compares them on each falling edge.

module tb_vend_fsm_multi;
  localparam int PRICE = 9, MAXC = 13, CW = 5, NP = 2, SW = 4, SINIT = 8;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          quarter = 0, dime = 0, nickel = 0, cancel = 0, restock = 0;
  logic [NP-1:0] sel = '0;
  logic [NP-1:0] vend, empty;
  logic          change, coin_reject, busy;
  logic [CW-1:0] credit;

  vend_fsm_multi #(.PRICE(PRICE), .MAX_CREDIT(MAXC), .CREDIT_W(CW), .N_PROD(NP),
                   .STOCK_W(SW), .STOCK_INIT(SINIT)) dut (
    .clk(clk), .rst_n(rst_n), .quarter(quarter), .dime(dime), .nickel(nickel),
    .sel(sel), .cancel(cancel), .restock(restock), .vend(vend), .change(change),
    .coin_reject(coin_reject), .credit(credit), .empty(empty), .busy(busy));

  always #5 clk = ~clk;

  typedef struct {
    int vend, change, rej, credit, empty, busy;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, errors = 0;
  bit   mon_en = 0;

  // The model tracks credit, stock per product, which product is being dispensed, and whether a refund is draining.
  int m_credit, m_vend, m_rej;
  bit m_drain;
  int m_stock[NP];

  task automatic model_reset();
    m_credit = 0; m_vend = -1; m_drain = 0; m_rej = 0;
    for (int i = 0; i < NP; i++) m_stock[i] = SINIT;
  endtask

  function automatic exp_t exp_now();
    exp_t e;
    e.vend   = (m_vend >= 0) ? (1 << m_vend) : 0;
    e.change = m_drain;
    e.rej    = m_rej;
    e.credit = m_credit;
    e.busy   = (m_vend >= 0) || m_drain;
    e.empty  = 0;
    for (int i = 0; i < NP; i++) if (m_stock[i] == 0) e.empty |= (1 << i);
    return e;
  endfunction

  task automatic model_step(input bit q, d, n, input logic [NP-1:0] s, input bit c, r);
    int coins = int'(q) + int'(d) + int'(n);
    int val   = q ? 5 : d ? 2 : n ? 1 : 0;
    int p     = -1;
    m_rej = 0;
    if (m_drain) begin
      m_credit = m_credit - 1;
      m_drain  = (m_credit > 0);
      m_rej    = (coins > 0);
    end else if (m_vend >= 0) begin
      m_vend  = -1;
      m_drain = (m_credit > 0);
      m_rej   = (coins > 0);
    end else if (c && m_credit > 0) begin
      m_drain = 1;
      m_rej   = (coins > 0);
    end else begin
      if (m_credit >= PRICE)
        for (int i = 0; i < NP; i++) if (p < 0 && s[i] && m_stock[i] > 0) p = i;
      if (p >= 0) begin
        m_vend = p; m_credit -= PRICE; m_stock[p]--; m_rej = (coins > 0);
      end else if (coins > 0) begin
        if (m_credit + val <= MAXC) m_credit += val;
        else m_rej = 1;
        if (coins > 1) m_rej = 1;
      end
    end
    if (r) for (int i = 0; i < NP; i++) m_stock[i] = SINIT;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (sb.size() == 0) chk("scoreboard_underflow", 0, 1);
      else begin
        e = sb.pop_front();
        chk("vend", int'(vend), e.vend);
        chk("change", int'(change), e.change);
        chk("coin_reject", int'(coin_reject), e.rej);
        chk("credit", int'(credit), e.credit);
        chk("empty", int'(empty), e.empty);
        chk("busy", int'(busy), e.busy);
      end
    end
  end

  // Each call starts 1 time unit after a rising edge, with one entry left in the queue.
  task automatic step(input bit q, d, n, input logic [NP-1:0] s, input bit c, r);
    quarter = q; dime = d; nickel = n; sel = s; cancel = c; restock = r;
    model_step(q, d, n, s, c, r);
    sb.push_back(exp_now());
    @(posedge clk); #1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 0, 0, '0, 0, 0);
  endtask

  task automatic do_reset();
    sb.delete();
    rst_n = 1'b0;
    quarter = 0; dime = 0; nickel = 0; sel = '0; cancel = 0; restock = 0;
    model_reset();
    sb.push_back(exp_now());
    @(posedge clk); #1;
    sb.push_back(exp_now());
    rst_n = 1'b1;
  endtask

  task automatic buy9(input logic [NP-1:0] s);
    step(1, 0, 0, '0, 0, 0); step(0, 1, 0, '0, 0, 0); step(0, 1, 0, '0, 0, 0);
    step(0, 0, 0, s, 0, 0);
    idle(2);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    sb.push_back(exp_now());
    mon_en = 1;
    rst_n  = 1'b1;

    buy9(2'b01);
    for (int i = 0; i < 3; i++) step(1, 0, 0, '0, 0, 0);
    step(0, 0, 0, 2'b10, 0, 0); idle(3);
    for (int i = 0; i < 3; i++) step(0, 0, 1, '0, 0, 0);
    step(0, 0, 0, '0, 1, 0); idle(4);
    for (int i = 1; i < SINIT; i++) buy9(2'b01);
    buy9(2'b01);
    step(0, 0, 0, 2'b11, 0, 0); idle(2);
    step(1, 0, 1, '0, 0, 0);
    step(1, 0, 0, '0, 0, 0);
    step(0, 0, 0, 2'b10, 0, 0);
    step(0, 0, 1, '0, 0, 0);
    step(1, 1, 0, '0, 0, 0); idle(2);
    step(0, 0, 0, '0, 0, 1);
    step(1, 0, 0, '0, 0, 0); step(1, 0, 0, '0, 0, 0);
    step(0, 0, 1, '0, 0, 0); step(0, 0, 1, '0, 0, 0);
    step(0, 0, 0, 2'b01, 0, 0);
    step(0, 0, 0, '0, 0, 0);
    step(0, 0, 0, '0, 0, 0);
    do_reset();
    idle(2);

    for (int k = 0; k < 3000; k++) begin
      bit q = ($urandom_range(0, 4) == 0);
      bit d = ($urandom_range(0, 4) == 0);
      bit n = ($urandom_range(0, 3) == 0);
      logic [NP-1:0] s = ($urandom_range(0, 3) == 0) ? NP'($urandom) : '0;
      bit c = ($urandom_range(0, 24) == 0);
      bit r = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 399) == 0) do_reset();
      else step(q, d, n, s, c, r);
    end

    @(negedge clk); #1;
    mon_en = 0;
    if (sb.size() != 0) chk("scoreboard_leftover", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
